// File: rtl/mbus_rx_msg_collector.sv
// MBus RX handshake collector: acks every received word or failure and queues
// framed entries in a first-word-fall-through FIFO for a valid/ready consumer.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// SYNC          | after reset, wait for RX_REQ/RX_FAIL low before capturing
// IDLE          | ready to capture a word or fail marker when FIFO has room
// WAIT_REQ_LOW  | word captured, RX_ACK high until RX_REQ drops
// WAIT_FAIL_LOW | fail marker captured, RX_ACK high until RX_FAIL drops
module mbus_rx_msg_collector #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] RX_ADDR,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_REQ,
  input  logic                  RX_PEND,
  input  logic                  RX_FAIL,
  input  logic                  RX_BROADCAST,
  output logic                  RX_ACK,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [ADDR_WIDTH-1:0] OUT_ADDR,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_LAST,
  output logic                  OUT_FAIL,
  output logic                  OUT_BCAST,
  output logic [15:0]           MSG_CNT,
  output logic [7:0]            FAIL_CNT,
  output logic                  OVF_SEEN
);

  typedef enum logic [1:0] {
    SYNC          = 2'd0,
    IDLE          = 2'd1,
    WAIT_REQ_LOW  = 2'd2,
    WAIT_FAIL_LOW = 2'd3
  } state_t;

  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

  state_t               state;
  logic [FIFO_AW:0]     count;
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic                 full;
  logic                 pop;
  logic                 push_en;
  logic                 push_fail;
  logic                 push_blocked;

  logic [ADDR_WIDTH-1:0] mem_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data  [FIFO_DEPTH];
  logic                  mem_bcast [FIFO_DEPTH];
  logic                  mem_last  [FIFO_DEPTH];
  logic                  mem_fail  [FIFO_DEPTH];

  assign full      = (count == FULL_CNT);
  assign OUT_VALID = (count != '0);
  assign pop       = OUT_VALID & OUT_READY;

  // Full check uses the pre-pop count, so a push at full waits a cycle.
  always_comb begin
    push_en      = 1'b0;
    push_fail    = 1'b0;
    push_blocked = 1'b0;
    if (state == IDLE) begin
      if (RX_FAIL && !full) begin
        push_en   = 1'b1;
        push_fail = 1'b1;
      end else if (RX_REQ && !full) begin
        push_en = 1'b1;
      end else if (RX_REQ || RX_FAIL) begin
        push_blocked = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= SYNC;
      RX_ACK <= 1'b0;
    end else begin
      case (state)
        SYNC: begin
          RX_ACK <= 1'b0;
          if (!RX_REQ && !RX_FAIL) state <= IDLE;
        end
        IDLE: begin
          if (push_en) begin
            RX_ACK <= 1'b1;
            state  <= push_fail ? WAIT_FAIL_LOW : WAIT_REQ_LOW;
          end
        end
        WAIT_REQ_LOW: begin
          if (!RX_REQ) begin
            RX_ACK <= 1'b0;
            state  <= IDLE;
          end
        end
        WAIT_FAIL_LOW: begin
          if (!RX_FAIL) begin
            RX_ACK <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          RX_ACK <= 1'b0;
          state  <= SYNC;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      MSG_CNT  <= '0;
      FAIL_CNT <= '0;
      OVF_SEEN <= 1'b0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_en && !push_fail && !RX_PEND && (MSG_CNT != 16'hFFFF))
        MSG_CNT <= MSG_CNT + 16'd1;
      if (push_fail && (FAIL_CNT != 8'hFF))
        FAIL_CNT <= FAIL_CNT + 8'd1;
      if (push_blocked)
        OVF_SEEN <= 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge CLK) begin
    if (push_en) begin
      mem_addr[wr_ptr]  <= RX_ADDR;
      mem_data[wr_ptr]  <= push_fail ? '0 : RX_DATA;
      mem_bcast[wr_ptr] <= RX_BROADCAST;
      mem_last[wr_ptr]  <= push_fail | ~RX_PEND;
      mem_fail[wr_ptr]  <= push_fail;
    end
  end

  assign OUT_ADDR  = mem_addr[rd_ptr];
  assign OUT_DATA  = mem_data[rd_ptr];
  assign OUT_BCAST = mem_bcast[rd_ptr];
  assign OUT_LAST  = mem_last[rd_ptr];
  assign OUT_FAIL  = mem_fail[rd_ptr];

endmodule

// File: tb/tb_mbus_rx_msg_collector.sv
// Scoreboard bench for mbus_rx_msg_collector: stimulus queues expected
// entries, a negedge monitor compares each popped head against the queue.
module tb_mbus_rx_msg_collector;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        bcast;
    logic        last;
    logic        fail;
  } entry_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] RX_ADDR = '0;
  logic [31:0] RX_DATA = '0;
  logic        RX_REQ = 1'b0;
  logic        RX_PEND = 1'b0;
  logic        RX_FAIL = 1'b0;
  logic        RX_BROADCAST = 1'b0;
  logic        RX_ACK;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT_ADDR;
  logic [31:0] OUT_DATA;
  logic        OUT_LAST;
  logic        OUT_FAIL;
  logic        OUT_BCAST;
  logic [15:0] MSG_CNT;
  logic [7:0]  FAIL_CNT;
  logic        OVF_SEEN;

  int     checks = 0;
  int     failures = 0;
  int     pop_cnt = 0;
  entry_t exp_q[$];

  mbus_rx_msg_collector #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(8), .FIFO_AW(3)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .RX_ADDR(RX_ADDR), .RX_DATA(RX_DATA), .RX_REQ(RX_REQ), .RX_PEND(RX_PEND),
    .RX_FAIL(RX_FAIL), .RX_BROADCAST(RX_BROADCAST), .RX_ACK(RX_ACK),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_ADDR(OUT_ADDR),
    .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST), .OUT_FAIL(OUT_FAIL),
    .OUT_BCAST(OUT_BCAST), .MSG_CNT(MSG_CNT), .FAIL_CNT(FAIL_CNT),
    .OVF_SEEN(OVF_SEEN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a head presented with OUT_READY high is consumed at the next edge.
  always @(negedge CLK) begin
    if (!RESET && OUT_VALID && OUT_READY) begin
      entry_t act;
      entry_t exp;
      act = {OUT_ADDR, OUT_DATA, OUT_BCAST, OUT_LAST, OUT_FAIL};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got %0h expected no entry", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          failures++;
          $display("FAIL pop_entry: got %0h expected %0h", act, exp);
        end
      end
      pop_cnt++;
    end
  end

  task automatic wait_ack(input logic lvl, input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (RX_ACK === lvl) break;
    end
    check(name, {63'd0, RX_ACK}, {63'd0, lvl});
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] d,
                           input logic pend, input logic bcast, input logic pulse);
    exp_q.push_back({a, d, bcast, ~pend, 1'b0});
    @(posedge CLK); #1;
    RX_ADDR = a; RX_DATA = d; RX_PEND = pend; RX_BROADCAST = bcast; RX_REQ = 1'b1;
    if (pulse) OUT_READY = 1'b1;
    @(posedge CLK); #1;
    if (pulse) OUT_READY = 1'b0;
    wait_ack(1'b1, "ack_rise");
    RX_REQ = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic send_fail(input logic [31:0] a, input logic bcast);
    exp_q.push_back({a, 32'd0, bcast, 1'b1, 1'b1});
    @(posedge CLK); #1;
    RX_ADDR = a; RX_BROADCAST = bcast; RX_FAIL = 1'b1;
    wait_ack(1'b1, "fail_ack_rise");
    repeat (2) @(negedge CLK);
    check("fail_ack_hold", {63'd0, RX_ACK}, 64'd1);
    RX_FAIL = 1'b0;
    wait_ack(1'b0, "fail_ack_fall");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0) break;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    check("drain_valid", {63'd0, OUT_VALID}, 64'd0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b1; RX_REQ = 1'b0; RX_FAIL = 1'b0; OUT_READY = 1'b0;
    exp_q.delete();
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("rst_ack", {63'd0, RX_ACK}, 64'd0);
    check("rst_valid", {63'd0, OUT_VALID}, 64'd0);
    check("rst_msg", {48'd0, MSG_CNT}, 64'd0);
    check("rst_fail", {56'd0, FAIL_CNT}, 64'd0);
    check("rst_ovf", {63'd0, OVF_SEEN}, 64'd0);

    // single word, timing of RX_ACK and head
    exp_q.push_back({32'h000000A5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0});
    @(posedge CLK); #1;
    RX_ADDR = 32'h000000A5; RX_DATA = 32'hDEADBEEF; RX_PEND = 1'b0; RX_REQ = 1'b1;
    @(negedge CLK);
    check("sw_ack_before", {63'd0, RX_ACK}, 64'd0);
    check("sw_valid_before", {63'd0, OUT_VALID}, 64'd0);
    @(negedge CLK);
    check("sw_ack_after", {63'd0, RX_ACK}, 64'd1);
    check("sw_valid", {63'd0, OUT_VALID}, 64'd1);
    check("sw_addr", {32'd0, OUT_ADDR}, 64'h000000A5);
    check("sw_data", {32'd0, OUT_DATA}, 64'hDEADBEEF);
    check("sw_last", {63'd0, OUT_LAST}, 64'd1);
    check("sw_failbit", {63'd0, OUT_FAIL}, 64'd0);
    check("sw_msg", {48'd0, MSG_CNT}, 64'd1);
    @(posedge CLK); #1;
    RX_REQ = 1'b0;
    @(negedge CLK);
    check("sw_ack_hold", {63'd0, RX_ACK}, 64'd1);
    @(negedge CLK);
    check("sw_ack_fall", {63'd0, RX_ACK}, 64'd0);
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    wait_drain();

    // 4-word broadcast message, streaming
    do_reset();
    OUT_READY = 1'b1;
    send_word(32'h11, 32'd1, 1'b1, 1'b1, 1'b0);
    send_word(32'h11, 32'd2, 1'b1, 1'b1, 1'b0);
    send_word(32'h11, 32'd3, 1'b1, 1'b1, 1'b0);
    send_word(32'h11, 32'd4, 1'b0, 1'b1, 1'b0);
    wait_drain();
    check("m4_msg", {48'd0, MSG_CNT}, 64'd1);

    // backpressure: FIFO fills at 8, 9th waits
    do_reset();
    base = pop_cnt;
    for (int i = 1; i <= 8; i++) send_word(32'h22, 32'(100 + i), 1'b0, 1'b0, 1'b0);
    check("bp_ovf_before", {63'd0, OVF_SEEN}, 64'd0);
    exp_q.push_back({32'h22, 32'd109, 1'b0, 1'b1, 1'b0});
    @(posedge CLK); #1;
    RX_ADDR = 32'h22; RX_DATA = 32'd109; RX_PEND = 1'b0; RX_REQ = 1'b1;
    repeat (3) @(negedge CLK);
    check("bp_ack_held", {63'd0, RX_ACK}, 64'd0);
    check("bp_ovf", {63'd0, OVF_SEEN}, 64'd1);
    check("bp_msg8", {48'd0, MSG_CNT}, 64'd8);
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    wait_ack(1'b1, "bp_ack_rise");
    RX_REQ = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");
    check("bp_one_pop", 64'(pop_cnt - base), 64'd1);
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    send_word(32'h22, 32'd110, 1'b0, 1'b0, 1'b0);
    wait_drain();
    check("bp_msg10", {48'd0, MSG_CNT}, 64'd10);
    check("bp_pops", 64'(pop_cnt - base), 64'd10);
    check("bp_ovf_sticky", {63'd0, OVF_SEEN}, 64'd1);

    // fail after 2 words of a multi-word message
    do_reset();
    OUT_READY = 1'b1;
    send_word(32'h30, 32'hA1, 1'b1, 1'b0, 1'b0);
    send_word(32'h30, 32'hA2, 1'b1, 1'b0, 1'b0);
    send_fail(32'h30, 1'b0);
    wait_drain();
    check("f_failcnt", {56'd0, FAIL_CNT}, 64'd1);
    check("f_msgcnt", {48'd0, MSG_CNT}, 64'd0);

    // reset mid-handshake with RX_REQ held
    do_reset();
    exp_q.push_back({32'h44, 32'h55, 1'b0, 1'b1, 1'b0});
    @(posedge CLK); #1;
    RX_ADDR = 32'h44; RX_DATA = 32'h55; RX_PEND = 1'b0; RX_REQ = 1'b1;
    wait_ack(1'b1, "r_ack_rise");
    @(posedge CLK); #1;
    RESET = 1'b1;
    exp_q.delete();
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("r_ack_low", {63'd0, RX_ACK}, 64'd0);
      check("r_no_capture", {63'd0, OUT_VALID}, 64'd0);
    end
    check("r_msg", {48'd0, MSG_CNT}, 64'd0);
    check("r_fail", {56'd0, FAIL_CNT}, 64'd0);
    @(posedge CLK); #1;
    RX_REQ = 1'b0;
    send_word(32'h77, 32'hCAFE, 1'b0, 1'b0, 1'b0);
    check("r_new_valid", {63'd0, OUT_VALID}, 64'd1);
    check("r_new_msg", {48'd0, MSG_CNT}, 64'd1);
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    wait_drain();

    // simultaneous push+pop at count 3, wraps pointers
    do_reset();
    base = pop_cnt;
    for (int i = 0; i < 3; i++) send_word(32'h50, 32'(32'h200 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) send_word(32'h50, 32'(32'h300 + i), 1'b0, 1'b0, 1'b1);
    check("pp_pops", 64'(pop_cnt - base), 64'd20);
    check("pp_valid", {63'd0, OUT_VALID}, 64'd1);
    check("pp_left", 64'(exp_q.size()), 64'd3);
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    wait_drain();
    check("pp_total", 64'(pop_cnt - base), 64'd23);
    check("pp_msg", {48'd0, MSG_CNT}, 64'd23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
